// File: rtl/multiplier_arbiter_tainttrack.sv
// Round-robin sequencer sharing one taint-tracking multiplier between NUM_REQ requesters.
// Every control and data output carries a shadow taint covering the arbitration decision.
module multiplier_arbiter_tainttrack #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_t,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a_t,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b_t,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         gnt_t,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [NUM_REQ-1:0]         rsp_valid_t,
  output logic [2*WIDTH-1:0]         rsp_product,
  output logic [2*WIDTH-1:0]         rsp_product_t,
  output logic                       busy,
  output logic                       mult_start,
  output logic                       mult_start_t,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  output logic [WIDTH-1:0]           mult_a_t,
  output logic [WIDTH-1:0]           mult_b_t,
  input  logic [2*WIDTH-1:0]         mult_product,
  input  logic [2*WIDTH-1:0]         mult_product_t,
  input  logic                       mult_done,
  input  logic                       mult_done_t
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      win_q, win_d;
  logic               arb_t_q, arb_t_d;
  logic               first_q, first_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, gnt_t_q, gnt_t_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d, rsp_valid_t_q, rsp_valid_t_d;
  logic [PW-1:0]      rsp_product_q, rsp_product_d, rsp_product_t_q, rsp_product_t_d;
  logic               mult_start_q, mult_start_d, mult_start_t_q, mult_start_t_d;
  logic [WIDTH-1:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [WIDTH-1:0]   mult_a_t_q, mult_a_t_d, mult_b_t_q, mult_b_t_d;

  logic [IW-1:0]      win_c;
  logic               found_c;
  logic               arb_c;
  logic               rsp_t_c;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    int unsigned cand;
    found_c = 1'b0;
    win_c   = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found_c && req[IW'(cand)]) begin
        found_c = 1'b1;
        win_c   = IW'(cand);
      end
    end
  end

  assign arb_c   = |req_t;
  assign rsp_t_c = arb_t_q | mult_done_t;

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    win_d           = win_q;
    arb_t_d         = arb_t_q;
    first_d         = first_q;
    gnt_d           = '0;
    gnt_t_d         = '0;
    rsp_valid_d     = '0;
    rsp_valid_t_d   = '0;
    rsp_product_d   = rsp_product_q;
    rsp_product_t_d = rsp_product_t_q;
    mult_start_d    = 1'b0;
    mult_start_t_d  = 1'b0;
    mult_a_d        = mult_a_q;
    mult_b_d        = mult_b_q;
    mult_a_t_d      = mult_a_t_q;
    mult_b_t_d      = mult_b_t_q;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          state_d        = S_START;
          win_d          = win_c;
          arb_t_d        = arb_c;
          mult_a_d       = req_a[win_c*WIDTH +: WIDTH];
          mult_b_d       = req_b[win_c*WIDTH +: WIDTH];
          mult_a_t_d     = req_a_t[win_c*WIDTH +: WIDTH] | {WIDTH{arb_c}};
          mult_b_t_d     = req_b_t[win_c*WIDTH +: WIDTH] | {WIDTH{arb_c}};
          gnt_d          = ONE_HOT0 << win_c;
          gnt_t_d        = (ONE_HOT0 << win_c) & {NUM_REQ{arb_c}};
          mult_start_d   = 1'b1;
          mult_start_t_d = arb_c;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        first_d = 1'b1;
      end
      S_WAIT: begin
        // The first WAIT cycle may still see the previous operation's done.
        first_d = 1'b0;
        if (!first_q && mult_done) begin
          state_d         = S_RESP;
          rsp_product_d   = mult_product;
          rsp_product_t_d = mult_product_t | {PW{rsp_t_c}};
          rsp_valid_d     = ONE_HOT0 << win_q;
          rsp_valid_t_d   = (ONE_HOT0 << win_q) & {NUM_REQ{rsp_t_c}};
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        last_d  = win_q;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      last_q          <= IW'(NUM_REQ - 1);
      win_q           <= '0;
      arb_t_q         <= 1'b0;
      first_q         <= 1'b0;
      busy_q          <= 1'b0;
      gnt_q           <= '0;
      gnt_t_q         <= '0;
      rsp_valid_q     <= '0;
      rsp_valid_t_q   <= '0;
      rsp_product_q   <= '0;
      rsp_product_t_q <= '0;
      mult_start_q    <= 1'b0;
      mult_start_t_q  <= 1'b0;
      mult_a_q        <= '0;
      mult_b_q        <= '0;
      mult_a_t_q      <= '0;
      mult_b_t_q      <= '0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      win_q           <= win_d;
      arb_t_q         <= arb_t_d;
      first_q         <= first_d;
      busy_q          <= busy_d;
      gnt_q           <= gnt_d;
      gnt_t_q         <= gnt_t_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_valid_t_q   <= rsp_valid_t_d;
      rsp_product_q   <= rsp_product_d;
      rsp_product_t_q <= rsp_product_t_d;
      mult_start_q    <= mult_start_d;
      mult_start_t_q  <= mult_start_t_d;
      mult_a_q        <= mult_a_d;
      mult_b_q        <= mult_b_d;
      mult_a_t_q      <= mult_a_t_d;
      mult_b_t_q      <= mult_b_t_d;
    end
  end

  assign gnt           = gnt_q;
  assign gnt_t         = gnt_t_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_valid_t   = rsp_valid_t_q;
  assign rsp_product   = rsp_product_q;
  assign rsp_product_t = rsp_product_t_q;
  assign busy          = busy_q;
  assign mult_start    = mult_start_q;
  assign mult_start_t  = mult_start_t_q;
  assign mult_a        = mult_a_q;
  assign mult_b        = mult_b_q;
  assign mult_a_t      = mult_a_t_q;
  assign mult_b_t      = mult_b_t_q;

endmodule

// File: tb/tb_multiplier_arbiter_tainttrack.sv
// Scoreboard bench for multiplier_arbiter_tainttrack with a behavioural multiplier model.
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares them.
module tb_multiplier_arbiter_tainttrack;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, req_t;
  logic [7:0] req_a, req_a_t, req_b, req_b_t;
  logic [1:0] gnt, gnt_t, rsp_valid, rsp_valid_t;
  logic [7:0] rsp_product, rsp_product_t;
  logic       busy, mult_start, mult_start_t;
  logic [3:0] mult_a, mult_b, mult_a_t, mult_b_t;
  logic [7:0] mult_product, mult_product_t;
  logic       mult_done, mult_done_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  lat     = 2;
  bit  stale   = 1'b0;
  bit  done_t_en = 1'b0;

  typedef struct {
    int         idx;
    logic [1:0] gt;
    logic       st;
    logic [3:0] a, b, at, bt;
  } gexp_t;

  typedef struct {
    int         idx;
    logic [7:0] p, pt;
    logic [1:0] vt;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  always #5 clk = ~clk;

  multiplier_arbiter_tainttrack #(.WIDTH(4), .NUM_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_t(req_t),
    .req_a(req_a), .req_a_t(req_a_t), .req_b(req_b), .req_b_t(req_b_t),
    .gnt(gnt), .gnt_t(gnt_t), .rsp_valid(rsp_valid), .rsp_valid_t(rsp_valid_t),
    .rsp_product(rsp_product), .rsp_product_t(rsp_product_t), .busy(busy),
    .mult_start(mult_start), .mult_start_t(mult_start_t),
    .mult_a(mult_a), .mult_b(mult_b), .mult_a_t(mult_a_t), .mult_b_t(mult_b_t),
    .mult_product(mult_product), .mult_product_t(mult_product_t),
    .mult_done(mult_done), .mult_done_t(mult_done_t)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_g(input int idx, input logic [1:0] gt, input logic st,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] at, input logic [3:0] bt);
    gexp_t e;
    e.idx = idx; e.gt = gt; e.st = st; e.a = a; e.b = b; e.at = at; e.bt = bt;
    gq.push_back(e);
  endtask

  task automatic push_r(input int idx, input logic [7:0] p, input logic [7:0] pt,
                        input logic [1:0] vt);
    rexp_t e;
    e.idx = idx; e.p = p; e.pt = pt; e.vt = vt;
    rq.push_back(e);
  endtask

  // Multiplier model: product_t is {a_t, b_t} so operand taint is observable.
  initial begin
    logic [3:0] pa, pb, pat, pbt;
    int l;
    mult_done = 1'b0; mult_done_t = 1'b0;
    mult_product = '0; mult_product_t = '0;
    forever begin
      @(negedge clk);
      if (mult_start) begin
        pa = mult_a; pb = mult_b; pat = mult_a_t; pbt = mult_b_t; l = lat;
        for (int i = 0; i < l; i++) begin
          @(negedge clk);
          mult_done      = stale && (i == 0);
          mult_done_t    = 1'b0;
          mult_product   = 8'hAA;
          mult_product_t = '0;
        end
        mult_done      = 1'b1;
        mult_done_t    = done_t_en;
        mult_product   = 8'(pa) * 8'(pb);
        mult_product_t = {pat, pbt};
        @(negedge clk);
        mult_done   = 1'b0;
        mult_done_t = 1'b0;
      end
    end
  end

  // Monitor: every grant / response pulse must match the next queued expectation.
  initial begin
    gexp_t g;
    rexp_t r;
    logic [1:0] oh;
    forever begin
      @(negedge clk);
      if (|gnt) begin
        if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'h0);
        else begin
          g  = gq.pop_front();
          oh = 2'b01 << g.idx;
          chk("gnt", 32'(gnt), 32'(oh));
          chk("gnt_t", 32'(gnt_t), 32'(g.gt));
          chk("mult_start", 32'(mult_start), 32'h1);
          chk("mult_start_t", 32'(mult_start_t), 32'(g.st));
          chk("mult_a", 32'(mult_a), 32'(g.a));
          chk("mult_b", 32'(mult_b), 32'(g.b));
          chk("mult_a_t", 32'(mult_a_t), 32'(g.at));
          chk("mult_b_t", 32'(mult_b_t), 32'(g.bt));
        end
      end
      if (|rsp_valid) begin
        if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
        else begin
          r  = rq.pop_front();
          oh = 2'b01 << r.idx;
          chk("rsp_valid", 32'(rsp_valid), 32'(oh));
          chk("rsp_product", 32'(rsp_product), 32'(r.p));
          chk("rsp_product_t", 32'(rsp_product_t), 32'(r.pt));
          chk("rsp_valid_t", 32'(rsp_valid_t), 32'(r.vt));
        end
      end
    end
  end

  // Wait for n grants; drop a requester once granted unless the load is continuous.
  task automatic serve(input int n, input bit drop);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (|gnt) begin
        got++;
        if (drop) req = req & ~gnt;
      end
    end
    chk("grants_seen", 32'(got), 32'(n));
    if (!drop) req = '0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((busy || rq.size() != 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_rsp", 32'(rq.size()), 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req = '0; req_t = '0;
    req_a = '0; req_a_t = '0; req_b = '0; req_b_t = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt", 32'({gnt, gnt_t}), 32'h0);
    chk("rst_rsp", 32'({rsp_valid, rsp_valid_t, rsp_product, rsp_product_t}), 32'h0);
    chk("rst_mult", 32'({mult_start, mult_start_t, mult_a, mult_b, mult_a_t, mult_b_t}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single requester 0, clean: 3*5
    push_g(0, 2'b00, 1'b0, 4'd3, 4'd5, 4'h0, 4'h0);
    push_r(0, 8'd15, 8'h00, 2'b00);
    req_a[3:0] = 4'd3; req_b[3:0] = 4'd5; req = 2'b01;
    serve(1, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("prod_hold", 32'(rsp_product), 32'd15);
    chk("prod_t_hold", 32'(rsp_product_t), 32'h0);

    // Both request after reset: requester 0 first, then 1
    pulse_reset();
    push_g(0, 2'b00, 1'b0, 4'd7, 4'd9, 4'h0, 4'h0);
    push_g(1, 2'b00, 1'b0, 4'd15, 4'd15, 4'h0, 4'h0);
    push_r(0, 8'd63, 8'h00, 2'b00);
    push_r(1, 8'd225, 8'h00, 2'b00);
    req_a = {4'd15, 4'd7}; req_b = {4'd15, 4'd9}; req = 2'b11;
    serve(2, 1'b1);
    wait_idle();

    // Continuous contention: last served was 1, so order 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      push_g(0, 2'b00, 1'b0, 4'd2, 4'd6, 4'h0, 4'h0);
      push_g(1, 2'b00, 1'b0, 4'd5, 4'd13, 4'h0, 4'h0);
      push_r(0, 8'd12, 8'h00, 2'b00);
      push_r(1, 8'd65, 8'h00, 2'b00);
    end
    req_a = {4'd5, 4'd2}; req_b = {4'd13, 4'd6}; req = 2'b11;
    serve(4, 1'b0);
    wait_idle();

    // Idle-but-tainted requester 1 taints the whole arbitration
    push_g(0, 2'b01, 1'b1, 4'd4, 4'd4, 4'hF, 4'hF);
    push_r(0, 8'd16, 8'hFF, 2'b01);
    req_a = {4'd0, 4'd4}; req_b = {4'd0, 4'd4}; req_t = 2'b10; req = 2'b01;
    serve(1, 1'b1);
    wait_idle();
    req_t = '0;

    // Requester 1 alone with one tainted operand bit: product taint from multiplier
    push_g(1, 2'b00, 1'b0, 4'd2, 4'd3, 4'h1, 4'h0);
    push_r(1, 8'd6, 8'h10, 2'b00);
    req_a = {4'd2, 4'd0}; req_b = {4'd3, 4'd0}; req_a_t = {4'h1, 4'h0}; req = 2'b10;
    serve(1, 1'b1);
    wait_idle();
    req_a_t = '0;

    // Stale done in first WAIT cycle must be ignored; done taint spreads to product
    lat = 3; stale = 1'b1; done_t_en = 1'b1;
    push_g(0, 2'b00, 1'b0, 4'd9, 4'd9, 4'h0, 4'h0);
    push_r(0, 8'd81, 8'hFF, 2'b01);
    req_a = {4'd0, 4'd9}; req_b = {4'd0, 4'd9}; req = 2'b01;
    serve(1, 1'b1);
    wait_idle();
    stale = 1'b0; done_t_en = 1'b0;

    // Reset in WAIT aborts without a response
    lat = 6;
    push_g(0, 2'b00, 1'b0, 4'd5, 4'd5, 4'h0, 4'h0);
    req_a = {4'd0, 4'd5}; req_b = {4'd0, 4'd5}; req = 2'b01;
    serve(1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rsp", 32'({rsp_valid, rsp_valid_t, rsp_product, rsp_product_t}), 32'h0);
    chk("abort_mult", 32'({mult_start, mult_start_t, mult_a, mult_b, mult_a_t, mult_b_t}), 32'h0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    lat = 2;
    @(negedge clk);
    push_g(1, 2'b00, 1'b0, 4'd6, 4'd7, 4'h0, 4'h0);
    push_r(1, 8'd42, 8'h00, 2'b00);
    req_a = {4'd6, 4'd0}; req_b = {4'd7, 4'd0}; req = 2'b10;
    serve(1, 1'b1);
    wait_idle();
    repeat (4) @(negedge clk);

    chk("grant_queue_empty", 32'(gq.size()), 32'h0);
    chk("rsp_queue_empty", 32'(rq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_arbiter_tainttrack.md
Name: multiplier_arbiter_tainttrack

Overview:
Round-robin arbiter/sequencer that shares one Multiplier_TaintTrack instance between NUM_REQ requesters. It latches the winning requester's operands and pulses the multiplier start. It waits for product completion, then returns the product to the winner with a one-cycle response pulse. Every control and data output carries a shadow taint signal, so information flow through arbitration is tracked as well as flow through the multiplier.

Parameters:
WIDTH, 4, operand width; product width is 2*WIDTH
NUM_REQ, 2, number of requesters (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level
req_t  in  NUM_REQ  taint of req
req_a  in  NUM_REQ*WIDTH  packed multiplier operands; requester i at [i*WIDTH +: WIDTH]
req_a_t  in  NUM_REQ*WIDTH  taint of req_a
req_b  in  NUM_REQ*WIDTH  packed multiplicand operands
req_b_t  in  NUM_REQ*WIDTH  taint of req_b
gnt  out  NUM_REQ  one-hot grant pulse
gnt_t  out  NUM_REQ  taint of gnt
rsp_valid  out  NUM_REQ  one-hot response pulse
rsp_valid_t  out  NUM_REQ  taint of rsp_valid
rsp_product  out  2*WIDTH  product for the requester flagged in rsp_valid
rsp_product_t  out  2*WIDTH  taint of rsp_product
busy  out  1  high in any state other than IDLE
mult_start  out  1  to multiplier start
mult_start_t  out  1  to multiplier start_t
mult_a, mult_b  out  WIDTH each  to multiplier and multiplicand
mult_a_t, mult_b_t  out  WIDTH each  operand taints
mult_product  in  2*WIDTH  from multiplier product
mult_product_t  in  2*WIDTH  from multiplier product_t
mult_done  in  1  from multiplier productDone
mult_done_t  in  1  from multiplier productDone_t

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last-winner pointer=NUM_REQ-1, so requester 0 has first priority.
  - All outputs and all internal registers are 0.
  - A reset in any state aborts the operation; no rsp_valid is issued for it.
- States IDLE -> START -> WAIT -> RESP -> IDLE.
- IDLE:
  - If req!=0, the winner is the first requester with req=1, searching from last+1 with wrap-around.
  - Register the winner index, its operands and operand taints.
  - Register arbitration taint arb_t = |req_t, because the choice depends on every req.
  - Go to START.
  - If req==0, stay in IDLE.
- START (exactly 1 cycle):
  - mult_start=1, gnt[winner]=1.
  - mult_a/mult_b hold the latched operands from START through WAIT.
  - gnt_t = {NUM_REQ{arb_t}} masked to the winner bit. mult_start_t = arb_t.
  - mult_a_t = latched a taint | {WIDTH{arb_t}}; mult_b_t likewise.
  - Go to WAIT.
- WAIT:
  - mult_done is ignored in the first WAIT cycle, so a stale done from the previous operation is not taken.
  - On the first later cycle with mult_done=1, latch mult_product and the taint (mult_product_t | {2*WIDTH{arb_t | mult_done_t}}), then go to RESP.
  - No timeout.
- RESP (exactly 1 cycle):
  - rsp_valid[winner]=1, rsp_product=latched product, rsp_product_t=latched taint.
  - rsp_valid_t[winner] = arb_t | latched done taint.
  - Update last pointer to winner and go to IDLE.
  - rsp_product holds its value until the next RESP; its taint also holds.
- Outside START and RESP: gnt, gnt_t, rsp_valid and rsp_valid_t are 0; mult_start and mult_start_t are 0.
- Requests arriving while busy are not acknowledged. A requester must hold req and its operands until it sees gnt. Operands are sampled only at the IDLE cycle in which arbitration occurs.
- Minimum latency from req to rsp_valid: 1 (IDLE) + 1 (START) + multiplier latency + 1 (RESP).
- Back-to-back service: the next arbitration happens in the IDLE cycle immediately after RESP.

Test Plan:
- WIDTH=4. Only req[0], a=3, b=5, all taints 0 -> gnt[0] pulses; rsp_valid[0] pulses with rsp_product=15; rsp_product_t=0, gnt_t=0.
- After reset, req=2'b11, requester 0 a=7 b=9, requester 1 a=15 b=15, held until grant -> requester 0 served first with 63, then requester 1 with 225; exactly one gnt pulse per requester.
- Both requesters request continuously for 4 operations -> grants alternate 0,1,0,1; no requester is granted twice in a row.
- req[0]=1, req_t=2'b10 (requester 1 idle but tainted), a_t=b_t=0 -> gnt_t[0]=1, mult_start_t=1, rsp_product_t=8'hFF, rsp_valid_t[0]=1.
- Only req[1], a_t=4'b0001, other taints 0, a=2 b=3 -> rsp_product=6; rsp_product_t equals mult_product_t from the multiplier; gnt_t=0.
- rst pulled low during WAIT -> immediate IDLE, all outputs 0, no rsp_valid. After release, req[1] alone -> served normally.
